dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_dmem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: CPU MEM-stage port, debug/loader port, SRAM port.
// Ports: slave = arbiter side, master = requesters + memory side.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;

  logic        dbg_req;
  logic        dbg_we;
  logic        dbg_lock;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dbg_req, dbg_we, dbg_lock,
    input  dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dbg_req, dbg_we, dbg_lock,
    output dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (CPU vs debug) with bounded CPU priority
// and a debug bus lock. Ports: clk, rst_n (async, active-low), bus (slave
// modport of dmem_arbiter_if), stall_cnt (stall-cycle counter, only counts
// when DMEM_ARB_PERF_EN is defined, else constant 0).
module dmem_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     bus,
  output logic [31:0]       stall_cnt
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       cpu_rv_q, dbg_rv_q;
  logic       cpu_gnt, dbg_gnt;
  logic       locked;
  logic       hold_max;

  // Lock only holds while dbg_lock stays high; the release cycle
  // already arbitrates normally.
  assign locked   = (state_q == LOCKED) && bus.dbg_lock;
  assign hold_max = (hold_q == 4'(MAX_HOLD));

  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst_n) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end else if (locked) begin
      dbg_gnt = bus.dbg_req;
    end else begin
      cpu_gnt = bus.cpu_req & ~(bus.dbg_req & hold_max);
      dbg_gnt = bus.dbg_req & ~cpu_gnt;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (locked || (dbg_gnt && bus.dbg_lock)) begin
      state_d = LOCKED;
    end else begin
      state_d = ARB;
    end
    if (dbg_gnt || !bus.dbg_req) begin
      hold_d = 4'd0;
    end else if (cpu_gnt && !hold_max) begin
      hold_d = hold_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      hold_q   <= 4'd0;
      cpu_rv_q <= 1'b0;
      dbg_rv_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cpu_rv_q <= cpu_gnt & ~bus.cpu_we;
      dbg_rv_q <= dbg_gnt & ~bus.dbg_we;
    end
  end

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (1'b1)
      cpu_gnt: begin
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end
      dbg_gnt: begin
        bus.mem_we    = bus.dbg_we;
        bus.mem_addr  = bus.dbg_addr;
        bus.mem_wdata = bus.dbg_wdata;
      end
      default: begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
      end
    endcase
  end

  assign bus.mem_en     = cpu_gnt | dbg_gnt;
  assign bus.cpu_stall  = rst_n & bus.cpu_req & ~cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.dbg_rvalid = dbg_rv_q;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dbg_rdata  = bus.mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d = stall_cnt_q + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (bus.cpu_stall) begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes per-cycle and
// read-data expectations, a negedge monitor pops and compares.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic        s, g, e, w, crv, drv, chk;
    logic [31:0] a, d, cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] stall_cnt;
  logic [31:0] mem [256];
  logic        done = 1'b0;
  logic        final_done = 1'b0;
  int          tests = 0;
  int          fails = 0;

  exp_t        exp_q[$];
  logic [31:0] cq[$];
  logic [31:0] dq[$];

  dmem_arbiter_if bus();

  dmem_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end
  end

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               n, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("cpu_stall", 32'(bus.cpu_stall), 32'(x.s));
      chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(x.g));
      chk("mem_en", 32'(bus.mem_en), 32'(x.e));
      chk("mem_we", 32'(bus.mem_we), 32'(x.w));
      chk("mem_addr", bus.mem_addr, x.a);
      chk("mem_wdata", bus.mem_wdata, x.d);
      chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(x.crv));
      chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(x.drv));
      if (x.chk) chk("stall_cnt", stall_cnt, x.cnt);
    end
    if (bus.cpu_rvalid) begin
      if (cq.size() != 0) chk("cpu_rdata", bus.cpu_rdata, cq.pop_front());
      else chk("cpu_rvalid_extra", 32'(bus.cpu_rvalid), 32'd0);
    end
    if (bus.dbg_rvalid) begin
      if (dq.size() != 0) chk("dbg_rdata", bus.dbg_rdata, dq.pop_front());
      else chk("dbg_rvalid_extra", 32'(bus.dbg_rvalid), 32'd0);
    end
    if (done && !final_done) begin
      chk("cpu_rd_left", 32'(cq.size()), 32'd0);
      chk("dbg_rd_left", 32'(dq.size()), 32'd0);
      chk("exp_left", 32'(exp_q.size()), 32'd0);
      final_done <= 1'b1;
    end
  end

  task automatic cyc(
    input logic cr, cw, input logic [31:0] ca, cd,
    input logic dr, dw, dl, input logic [31:0] da, dd,
    input logic s, g, e, w, crv, drv,
    input logic [31:0] a, d,
    input logic ck, input logic [31:0] cnt);
    exp_t x;
    @(posedge clk);
    #1;
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.dbg_req   = dr;
    bus.dbg_we    = dw;
    bus.dbg_lock  = dl;
    bus.dbg_addr  = da;
    bus.dbg_wdata = dd;
    x.s = s; x.g = g; x.e = e; x.w = w;
    x.crv = crv; x.drv = drv;
    x.a = a; x.d = d; x.chk = ck; x.cnt = cnt;
    exp_q.push_back(x);
  endtask

  task automatic idle(input logic crv, drv, ck,
                      input logic [31:0] cnt);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, crv, drv, 0, 0, ck, cnt);
  endtask

  task automatic release_idle();
    #6;
    bus.cpu_req  = 1'b0;
    bus.dbg_req  = 1'b0;
    bus.dbg_lock = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic pulse_reset();
    #6 rst_n = 1'b0;
    @(posedge clk);
    #6 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.mem_rdata = '0;
    bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_lock = 0;
    bus.dbg_addr = 0; bus.dbg_wdata = 0;

    // Reset held with both requests present: outputs forced low
    cyc(1, 0, 100, 0, 1, 0, 1, 136, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    release_idle();

    // CPU store then load
    cyc(1, 1, 100, 25, 0, 0, 0, 0, 0,
        0, 0, 1, 1, 0, 0, 100, 25, 1, 0);
    cyc(1, 0, 100, 0, 0, 0, 0, 0, 0,
        0, 0, 1, 0, 0, 0, 100, 0, 0, 0);
    cq.push_back(32'd25);
    idle(1, 0, 1, 0);
    pulse_reset();

    // Contention: 4 CPU grants, then debug, then CPU
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1, 32'(64 + 4 * k), 32'(k), 1, 0, 0, 100, 0,
          0, 0, 1, 1, 0, 0, 32'(64 + 4 * k), 32'(k), 0, 0);
    end
    cyc(1, 1, 80, 4, 1, 0, 0, 100, 0,
        1, 1, 1, 0, 0, 0, 100, 0, 0, 0);
    dq.push_back(32'd25);
    cyc(1, 1, 80, 4, 1, 0, 0, 100, 0,
        0, 0, 1, 1, 0, 1, 80, 4, 0, 0);
    idle(0, 0, 1, PERF ? 32'd1 : 32'd0);
    pulse_reset();

    // Locked debug read of 136, then three locked writes
    cyc(0, 0, 0, 0, 1, 0, 1, 136, 0,
        0, 1, 1, 0, 0, 0, 136, 0, 0, 0);
    dq.push_back(32'd0);
    cyc(1, 0, 204, 0, 1, 1, 1, 200, 200,
        1, 1, 1, 1, 0, 1, 200, 200, 0, 0);
    cyc(1, 0, 204, 0, 1, 1, 1, 204, 204,
        1, 1, 1, 1, 0, 0, 204, 204, 0, 0);
    cyc(1, 0, 204, 0, 1, 1, 1, 208, 208,
        1, 1, 1, 1, 0, 0, 208, 208, 0, 0);
    cyc(1, 0, 204, 0, 0, 0, 0, 0, 0,
        0, 0, 1, 0, 0, 0, 204, 0, 1, PERF ? 32'd3 : 32'd0);
    cq.push_back(32'd204);
    idle(1, 0, 1, PERF ? 32'd3 : 32'd0);

    // Reset in the middle of a locked debug read
    cyc(0, 0, 0, 0, 1, 1, 1, 300, 1,
        0, 1, 1, 1, 0, 0, 300, 1, 0, 0);
    cyc(1, 1, 400, 7, 1, 0, 1, 100, 0,
        1, 1, 1, 0, 0, 0, 100, 0, 0, 0);
    #6 rst_n = 1'b0;
    cyc(1, 1, 400, 7, 1, 0, 1, 100, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #6 rst_n = 1'b1;
    cyc(1, 1, 400, 7, 1, 0, 1, 100, 0,
        0, 0, 1, 1, 0, 0, 400, 7, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 100, 0,
        0, 1, 1, 0, 0, 0, 100, 0, 0, 0);
    dq.push_back(32'd25);
    idle(0, 1, 0, 0);
    cyc(1, 0, 400, 0, 1, 1, 0, 500, 9,
        0, 0, 1, 0, 0, 0, 400, 0, 0, 0);
    cq.push_back(32'd7);
    cyc(0, 0, 0, 0, 1, 1, 0, 500, 9,
        0, 1, 1, 1, 1, 0, 500, 9, 0, 0);
    idle(0, 0, 0, 0);

    done = 1'b1;
    for (int i = 0; i < 5 && !final_done; i++) @(posedge clk);
    if (!final_done) begin
      fails++;
      $display("FAIL final_check: monitor did not complete");
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
